seg7_scan_driver: RTL and testbench

//  Output-side counterpart of the push-button input path: drives the board's multiplexed

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/hex_to_7seg.sv | 9 +
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table and
// output polarities of the common-anode display.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       AN_OFF  = 1'b1;
    localparam logic       DP_OFF  = 1'b1;

    // Active-high {g,f,e,d,c,b,a}; element k is the glyph for nibble k
    localparam logic [15:0][6:0] HEX7 = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } slot_st_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data-in / display-out bundle of the scan driver.
// master = data source + observer, slave = the driver itself.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      frame_done;

    modport master (
        output load, value, dp_mask, blank_mask,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  load, value, dp_mask, blank_mask,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/hex_to_7seg.sv
// Nibble to active-high 7-segment glyph, purely combinational.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX7[nib_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display scanner with per-slot blanking
// and frame-boundary data swap.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic Clk,
    input  logic Reset,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam slot_st_e ST_RST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    slot_st_e              st_q, st_d;
    logic [VAL_W-1:0]      val_q, val_d, pval_q, pval_d;
    logic [NUM_DIGITS-1:0] dpm_q, dpm_d, pdpm_q, pdpm_d;
    logic [NUM_DIGITS-1:0] blm_q, blm_d, pblm_q, pblm_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fd_q, fd_d;

    logic       slot_end;
    logic       frame_wrap;
    logic [3:0] nib;
    logic [6:0] glyph;

    assign slot_end   = (cnt_q == CNT_MAX);
    assign frame_wrap = slot_end && (idx_q == IDX_MAX);
    assign nib        = val_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_hex (
        .nib_i (nib),
        .seg_o (glyph)
    );

    // Slot timing; the state follows the counter value it will hold next
    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        st_d = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
    end

    always_comb begin
        val_d  = val_q;
        dpm_d  = dpm_q;
        blm_d  = blm_q;
        pval_d = pval_q;
        pdpm_d = pdpm_q;
        pblm_d = pblm_q;
        pend_d = pend_q;
        if (frame_wrap) begin
            pend_d = 1'b0;
            if (bus.load) begin
                val_d = bus.value;
                dpm_d = bus.dp_mask;
                blm_d = bus.blank_mask;
            end else if (pend_q) begin
                val_d = pval_q;
                dpm_d = pdpm_q;
                blm_d = pblm_q;
            end
        end else if (bus.load) begin
            pval_d = bus.value;
            pdpm_d = bus.dp_mask;
            pblm_d = bus.blank_mask;
            pend_d = 1'b1;
        end
    end

    always_comb begin
        an_d  = {NUM_DIGITS{AN_OFF}};
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        fd_d  = frame_wrap;
        if (st_q == ST_DRIVE && !blm_q[idx_q]) begin
            an_d[idx_q] = ~AN_OFF;
            seg_d       = ~glyph;
            dp_d        = ~dpm_q[idx_q];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            st_q   <= ST_RST;
            val_q  <= '0;
            dpm_q  <= '0;
            blm_q  <= '0;
            pval_q <= '0;
            pdpm_q <= '0;
            pblm_q <= '0;
            pend_q <= 1'b0;
            an_q   <= {NUM_DIGITS{AN_OFF}};
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            st_q   <= st_d;
            val_q  <= val_d;
            dpm_q  <= dpm_d;
            blm_q  <= blm_d;
            pval_q <= pval_d;
            pdpm_q <= pdpm_d;
            pblm_q <= pblm_d;
            pend_q <= pend_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            fd_q   <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: reference model feeding a
// scoreboard queue, plus per-frame glyph tables for the display cases.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } out_t;

    typedef struct {
        out_t exp;
        int   pos;
    } sb_t;

    typedef struct {
        int         set;
        int         dig;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    localparam out_t RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic Clk = 1'b0;
    logic Reset;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #10 Clk = ~Clk;

    logic [6:0] hx [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    sb_t  q[$];
    out_t obs [16];
    vec_t tbl [20];
    int   checks   = 0;
    int   failures = 0;
    int   last_pos = -1;

    int          m_cnt, m_idx;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dpm, m_blm, p_dpm, p_blm;
    bit          p_flag;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic out_t model_out();
        out_t       r;
        logic [3:0] nib;
        r    = RST_OUT;
        r.fd = (m_idx == ND - 1) && (m_cnt == RD - 1);
        if (m_cnt >= BC && !m_blm[m_idx]) begin
            nib         = m_val[m_idx*4 +: 4];
            r.an[m_idx] = 1'b0;
            r.seg       = ~hx[nib];
            r.dp        = ~m_dpm[m_idx];
        end
        return r;
    endfunction

    task automatic step(input logic rst, input logic ld,
                        input logic [15:0] v, input logic [3:0] dpm,
                        input logic [3:0] blm);
        sb_t  e;
        out_t o;
        bit   wrap;
        @(negedge Clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            o = {bus.an, bus.seg, bus.dp, bus.frame_done};
            chk($sformatf("sb pos%0d", e.pos), {19'd0, o}, {19'd0, e.exp});
            last_pos = e.pos;
            if (e.pos >= 0) obs[e.pos] = o;
        end
        Reset          = rst;
        bus.load       = ld;
        bus.value      = v;
        bus.dp_mask    = dpm;
        bus.blank_mask = blm;
        e.pos = rst ? m_idx * RD + m_cnt : -1;
        e.exp = rst ? model_out() : RST_OUT;
        q.push_back(e);
        if (!rst) begin
            m_cnt  = 0;
            m_idx  = 0;
            m_val  = '0;
            m_dpm  = '0;
            m_blm  = '0;
            p_val  = '0;
            p_dpm  = '0;
            p_blm  = '0;
            p_flag = 1'b0;
        end else begin
            wrap = (m_cnt == RD - 1) && (m_idx == ND - 1);
            if (wrap) begin
                if (ld) begin
                    m_val = v;
                    m_dpm = dpm;
                    m_blm = blm;
                end else if (p_flag) begin
                    m_val = p_val;
                    m_dpm = p_dpm;
                    m_blm = p_blm;
                end
                p_flag = 1'b0;
            end else if (ld) begin
                p_val  = v;
                p_dpm  = dpm;
                p_blm  = blm;
                p_flag = 1'b1;
            end
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dpm,
                        input logic [3:0] blm);
        step(1'b1, 1'b1, v, dpm, blm);
    endtask

    task automatic to_frame_end();
        int n = 0;
        do begin
            idle();
            n++;
        end while (last_pos != 15 && n < 40);
        if (n >= 40) chk("frame_end_bound", n, 0);
    endtask

    task automatic step_until(input int p);
        int n = 0;
        while ((m_idx * RD + m_cnt) != p && n < 20) begin
            idle();
            n++;
        end
        if (n >= 20) chk("step_until_bound", n, 0);
    endtask

    task automatic check_set(input int s);
        out_t o;
        foreach (tbl[i]) begin
            if (tbl[i].set == s) begin
                for (int c = 0; c < RD; c++) begin
                    o = obs[tbl[i].dig * RD + c];
                    if (c < BC)
                        chk($sformatf("set%0d d%0d blank", s, tbl[i].dig),
                            {21'd0, o.an, o.seg}, {21'd0, 4'hF, 7'h7F});
                    else
                        chk($sformatf("set%0d d%0d c%0d", s, tbl[i].dig, c),
                            {21'd0, o.an, o.seg},
                            {21'd0, tbl[i].an, tbl[i].seg});
                end
            end
        end
    endtask

    task automatic check_fd();
        int n = 0;
        for (int p = 0; p < 16; p++) n += int'(obs[p].fd);
        chk("fd_per_frame", n, 1);
        chk("fd_last_d3", {31'd0, obs[15].fd}, 1);
    endtask

    initial begin
        int          n0111;
        logic [15:0] dpv;
        tbl = '{
            '{0, 0, 4'hE, 7'h40}, '{0, 1, 4'hD, 7'h40},
            '{0, 2, 4'hB, 7'h40}, '{0, 3, 4'h7, 7'h40},
            '{1, 0, 4'hE, 7'h19}, '{1, 1, 4'hD, 7'h30},
            '{1, 2, 4'hB, 7'h24}, '{1, 3, 4'h7, 7'h79},
            '{2, 0, 4'hE, 7'h21}, '{2, 1, 4'hD, 7'h46},
            '{2, 2, 4'hB, 7'h03}, '{2, 3, 4'h7, 7'h08},
            '{3, 0, 4'hE, 7'h24}, '{3, 1, 4'hD, 7'h24},
            '{3, 2, 4'hB, 7'h24}, '{3, 3, 4'h7, 7'h24},
            '{4, 0, 4'hE, 7'h40}, '{4, 1, 4'hD, 7'h0E},
            '{4, 2, 4'hB, 7'h40}, '{4, 3, 4'h7, 7'h40}
        };
        Reset          = 1'b0;
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.dp_mask    = '0;
        bus.blank_mask = '0;

        repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        load(16'h1234, 4'h0, 4'h0);
        to_frame_end();
        check_set(0);
        to_frame_end();
        check_set(1);
        check_fd();
        repeat (2) begin
            to_frame_end();
            check_fd();
        end

        step_until(5);
        load(16'hABCD, 4'h0, 4'h0);
        to_frame_end();
        check_set(1);
        to_frame_end();
        check_set(2);

        step_until(2);
        load(16'h1111, 4'h0, 4'h0);
        step_until(9);
        load(16'h2222, 4'h0, 4'h0);
        to_frame_end();
        check_set(2);
        to_frame_end();
        check_set(3);

        step_until(15);
        load(16'h00F0, 4'h0, 4'h0);
        to_frame_end();
        check_set(3);
        to_frame_end();
        check_set(4);

        step_until(15);
        load(16'h1234, 4'b0001, 4'b1000);
        to_frame_end();
        to_frame_end();
        n0111 = 0;
        dpv   = '0;
        for (int p = 0; p < 16; p++) begin
            if (obs[p].an == 4'b0111) n0111++;
            dpv[p] = ~obs[p].dp;
        end
        chk("an_d3_never", n0111, 0);
        chk("dp_d0_only", {16'd0, dpv}, 32'h0000_000E);
        chk("d3_dark", {21'd0, obs[13].an, obs[13].seg},
            {21'd0, 4'hF, 7'h7F});
        chk("d0_glyph", {25'd0, obs[2].seg}, 32'h19);

        step_until(5);
        load(16'h5555, 4'h0, 4'h0);
        step_until(9);
        step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        to_frame_end();
        check_set(0);
        to_frame_end();
        check_set(0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
